// File: rtl/gas_pkg.sv
// Shared defaults and helpers for the multi-channel gas pattern alarm.
package gas_pkg;

  localparam int unsigned PAT_LEN_DEF  = 6;
  localparam logic [5:0]  PATTERN_DEF  = 6'b101101;
  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned ALARM_TH_DEF = 3;

  // Width needed to count 0..pat_len inclusive.
  function automatic int unsigned fill_w(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/gas_pattern_channel.sv
// One sensor channel: history shift register, fill tracking, masked match,
// saturating hit counter and latched alarm.
module gas_pattern_channel
  import gas_pkg::*;
#(
  parameter int unsigned PAT_LEN  = PAT_LEN_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned ALARM_TH = ALARM_TH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic               x_bit,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic               alarm_ack,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN-1:0] mask,
  output logic               z,
  output logic               alarm,
  output logic               alarm_nxt_c,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int unsigned FILL_W = fill_w(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_TH    = CNT_W'(ALARM_TH);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d;
  logic               alarm_q, alarm_d;
  logic               match_c;

  // Next history/fill, match decision, counter and alarm update.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    z_d     = 1'b0;

    hist_n  = {hist_q[PAT_LEN-2:0], x_bit};
    fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match_c = sample_valid && !pat_load && (fill_n == FILL_FULL) &&
              (((hist_n ^ pattern) & mask) == '0);

    if (alarm_ack) begin
      cnt_d   = '0;
      alarm_d = 1'b0;
    end

    // A pattern reload discards the concurrent sample and restarts the window.
    if (pat_load) begin
      fill_d = '0;
    end else if (sample_valid) begin
      hist_d = hist_n;
      fill_d = (match_c && !overlap_en) ? '0 : fill_n;
    end

    if (match_c) begin
      z_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
      if (cnt_d >= CNT_TH) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      alarm_q <= alarm_d;
    end
  end

  assign z           = z_q;
  assign alarm       = alarm_q;
  assign alarm_nxt_c = alarm_d;
  assign hit_cnt     = cnt_q;

endmodule

// File: rtl/gas_pattern_alarm.sv
// Multi-channel maskable serial-pattern detector with per-channel hit counters
// and latched alarms; holds the shared runtime-loadable pattern and mask.
module gas_pattern_alarm
  import gas_pkg::*;
#(
  parameter int unsigned        NCH      = 4,
  parameter int unsigned        PAT_LEN  = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN  = PAT_LEN'(PATTERN_DEF),
  parameter int unsigned        CNT_W    = CNT_W_DEF,
  parameter int unsigned        ALARM_TH = ALARM_TH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 sample_valid,
  input  logic [NCH-1:0]       x,
  input  logic                 overlap_en,
  input  logic                 pat_load,
  input  logic [PAT_LEN-1:0]   pat_value,
  input  logic [PAT_LEN-1:0]   pat_mask,
  input  logic [NCH-1:0]       alarm_ack,
  output logic [NCH-1:0]       Z,
  output logic [NCH-1:0]       alarm,
  output logic                 any_alarm,
  output logic [NCH*CNT_W-1:0] hit_cnt
);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] mask_q, mask_d;
  logic               any_alarm_q, any_alarm_d;
  logic [NCH-1:0]     alarm_nxt;

  // Pattern/mask load and registered OR of the upcoming alarm vector.
  always_comb begin
    pat_d       = pat_q;
    mask_d      = mask_q;
    any_alarm_d = |alarm_nxt;
    if (pat_load) begin
      pat_d  = pat_value;
      mask_d = pat_mask;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q       <= PATTERN;
      mask_q      <= '1;
      any_alarm_q <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      mask_q      <= mask_d;
      any_alarm_q <= any_alarm_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gas_pattern_channel #(
      .PAT_LEN  (PAT_LEN),
      .CNT_W    (CNT_W),
      .ALARM_TH (ALARM_TH)
    ) u_ch (
      .clk          (CLK),
      .rst          (RST),
      .sample_valid (sample_valid),
      .x_bit        (x[i]),
      .overlap_en   (overlap_en),
      .pat_load     (pat_load),
      .alarm_ack    (alarm_ack[i]),
      .pattern      (pat_q),
      .mask         (mask_q),
      .z            (Z[i]),
      .alarm        (alarm[i]),
      .alarm_nxt_c  (alarm_nxt[i]),
      .hit_cnt      (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign any_alarm = any_alarm_q;

endmodule

// File: tb/tb_gas_pattern_alarm.sv
// Directed self-checking bench for gas_pattern_alarm (NCH=4, PAT_LEN=6).
module tb_gas_pattern_alarm;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sample_valid;
  logic [3:0]  x;
  logic        overlap_en;
  logic        pat_load;
  logic [5:0]  pat_value;
  logic [5:0]  pat_mask;
  logic [3:0]  alarm_ack;
  logic [3:0]  Z;
  logic [3:0]  alarm;
  logic        any_alarm;
  logic [15:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  gas_pattern_alarm dut (
    .CLK          (CLK),
    .RST          (RST),
    .sample_valid (sample_valid),
    .x            (x),
    .overlap_en   (overlap_en),
    .pat_load     (pat_load),
    .pat_value    (pat_value),
    .pat_mask     (pat_mask),
    .alarm_ack    (alarm_ack),
    .Z            (Z),
    .alarm        (alarm),
    .any_alarm    (any_alarm),
    .hit_cnt      (hit_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input logic [3:0] xv);
    sample_valid = 1'b1;
    x = xv;
    tick();
    sample_valid = 1'b0;
    x = '0;
  endtask

  // Feed bits[n-1] first on one channel (others 0); zexp bit i is that sample's Z.
  task automatic feed(input int ch, input logic [15:0] bits, input int n,
                      input logic [15:0] zexp, input string tag);
    logic [3:0] xv;
    logic [3:0] ez;
    for (int i = n - 1; i >= 0; i--) begin
      xv = '0;
      xv[ch] = bits[i];
      ez = '0;
      ez[ch] = zexp[i];
      sample(xv);
      chk(tag, 32'(Z), 32'(ez));
    end
  endtask

  task automatic reload(input logic [5:0] v, input logic [5:0] m);
    pat_load = 1'b1;
    pat_value = v;
    pat_mask = m;
    tick();
    pat_load = 1'b0;
    chk("reload_z", 32'(Z), 32'h0);
  endtask

  task automatic ack(input logic [3:0] a);
    alarm_ack = a;
    tick();
    alarm_ack = '0;
  endtask

  initial begin
    logic [5:0]  c1;
    logic [5:0]  c2;
    logic [3:0]  ez;
    logic [3:0]  ea;
    logic [15:0] ec;
    int m;
    int c0;

    RST = 1'b1; sample_valid = 1'b0; x = '0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_value = '0; pat_mask = '0; alarm_ack = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_z", 32'(Z), 32'h0);
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_any", 32'(any_alarm), 32'h0);
    chk("rst_cnt", 32'(hit_cnt), 32'h0);

    // Partial window never matches
    feed(0, 16'h0, 5, 16'h0, "fill_z");

    // Basic match on ch0
    feed(0, 16'(6'b101101), 6, 16'(6'b000001), "basic_z");
    tick();
    chk("no_valid_z", 32'(Z), 32'h0);
    chk("basic_cnt", 32'(hit_cnt), 32'h0001);
    ack(4'b0001);
    chk("ack_cnt", 32'(hit_cnt), 32'h0);

    // Overlapping vs non-overlapping
    reload(6'b101101, 6'b111111);
    overlap_en = 1'b1;
    feed(0, 16'(9'b101101101), 9, 16'(9'b000001001), "ovl_z");
    chk("ovl_cnt", 32'(hit_cnt), 32'h0002);
    chk("ovl_alarm", 32'(alarm), 32'h0);
    reload(6'b101101, 6'b111111);
    overlap_en = 1'b0;
    feed(0, 16'(6'b101101), 6, 16'(6'b000001), "novl_z");
    chk("th_alarm", 32'(alarm), 32'h1);
    chk("th_any", 32'(any_alarm), 32'h1);
    feed(0, 16'(3'b101), 3, 16'h0, "novl_tail_z");
    chk("novl_cnt", 32'(hit_cnt), 32'h0003);
    ack(4'b0001);
    chk("ack2_cnt", 32'(hit_cnt), 32'h0);
    chk("ack2_alarm", 32'(alarm), 32'h0);
    chk("ack2_any", 32'(any_alarm), 32'h0);

    // Masked pattern: ch1 matches, ch2 does not
    overlap_en = 1'b1;
    reload(6'b100001, 6'b100001);
    c1 = 6'b110101;
    c2 = 6'b011111;
    for (int i = 5; i >= 0; i--) begin
      sample({1'b0, c2[i], c1[i], 1'b0});
      chk("mask_z", 32'(Z), (i == 0) ? 32'h2 : 32'h0);
    end
    chk("mask_cnt", 32'(hit_cnt), 32'h0010);
    ack(4'b0010);
    chk("ack_ch1_cnt", 32'(hit_cnt), 32'h0);

    // Mask all zeros: every full window matches on every channel
    reload(6'b000000, 6'b000000);
    for (int k = 1; k <= 26; k++) begin
      alarm_ack = (k == 9) ? 4'b0001 : 4'b0000;
      sample(4'b0000);
      alarm_ack = '0;
      m  = (k >= 6) ? k - 5 : 0;
      c0 = (k >= 9) ? k - 8 : m;
      if (m > 15) m = 15;
      if (c0 > 15) c0 = 15;
      ez = (k >= 6) ? 4'hF : 4'h0;
      ec = {4'(m), 4'(m), 4'(m), 4'(c0)};
      ea = {3'((m >= 3) ? 3'b111 : 3'b000), 1'(c0 >= 3)};
      chk("m0_z", 32'(Z), 32'(ez));
      chk("m0_cnt", 32'(hit_cnt), 32'(ec));
      chk("m0_alarm", 32'(alarm), 32'(ea));
      chk("m0_any", 32'(any_alarm), 32'(ea != 4'h0));
    end
    ack(4'b1111);
    chk("ackall_cnt", 32'(hit_cnt), 32'h0);
    chk("ackall_alarm", 32'(alarm), 32'h0);
    chk("ackall_any", 32'(any_alarm), 32'h0);

    // Load with concurrent sample: sample dropped, window restarts
    reload(6'b101101, 6'b111111);
    feed(0, 16'(4'b1011), 4, 16'h0, "pre_load_z");
    pat_load = 1'b1; sample_valid = 1'b1; x = 4'b0001;
    pat_value = 6'b101101; pat_mask = 6'b111111;
    tick();
    pat_load = 1'b0; sample_valid = 1'b0; x = '0;
    chk("load_drop_z", 32'(Z), 32'h0);
    feed(0, 16'(2'b01), 2, 16'h0, "post_load_z");
    chk("post_load_cnt", 32'(hit_cnt), 32'h0);

    // Reset mid-sequence restores default pattern and clears everything
    reload(6'b010010, 6'b111111);
    feed(0, 16'(6'b010010), 6, 16'(6'b000001), "alt_pat_z");
    chk("alt_pat_cnt", 32'(hit_cnt), 32'h0001);
    feed(0, 16'(4'b1011), 4, 16'h0, "alt_tail_z");
    RST = 1'b1; sample_valid = 1'b1; x = 4'b0001;
    tick();
    RST = 1'b0; sample_valid = 1'b0; x = '0;
    chk("mid_rst_z", 32'(Z), 32'h0);
    chk("mid_rst_cnt", 32'(hit_cnt), 32'h0);
    chk("mid_rst_alarm", 32'(alarm), 32'h0);
    chk("mid_rst_any", 32'(any_alarm), 32'h0);
    feed(0, 16'(6'b101101), 6, 16'(6'b000001), "default_pat_z");
    chk("default_pat_cnt", 32'(hit_cnt), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
